// File: rtl/clock_group_reset_sequencer.sv
// Staggered reset release for a group of members sharing one clock, with
// software-requested re-reset of a subset of members.
`timescale 1ns/1ps
module clock_group_reset_sequencer #(
    parameter int NUM_MEMBERS = 3,
    parameter int GAP_CYCLES  = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [NUM_MEMBERS-1:0] auto_out_member_clock,
    output logic [NUM_MEMBERS-1:0] auto_out_member_reset,
    input  logic                   req_valid,
    input  logic [NUM_MEMBERS-1:0] req_mask,
    output logic                   req_ready,
    output logic                   done,
    output logic                   busy
);

    typedef enum logic [1:0] {SYNC, RELEASE, RUN, HOLD} state_t;

    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0]             rst_sync_q, rst_sync_d;
    logic                   rst_int_n;
    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MEMBERS-1:0] mrst_q, mrst_d;
    logic [NUM_MEMBERS-1:0] act_q, act_d;
    logic [NUM_MEMBERS-1:0] pend_q, pend_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic [NUM_MEMBERS-1:0] src, pick;
    logic                   rel_evt;

    assign auto_out_member_clock = {NUM_MEMBERS{clock}};
    assign auto_out_member_reset = mrst_q;
    assign req_ready             = ready_q;
    assign done                  = done_q;
    assign busy                  = (state_q != RUN);

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    // Members still waiting come from the latched mask until RELEASE starts
    // consuming them; the lowest pending bit is always the next to release.
    always_comb begin
        src  = (state_q == RELEASE) ? pend_q : act_q;
        pick = src & (~src + NUM_MEMBERS'(1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        mrst_d  = mrst_q;
        act_d   = act_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        rel_evt = 1'b0;
        case (state_q)
            SYNC:    rel_evt = (cnt_q == GAP_LAST);
            RELEASE: rel_evt = (cnt_q == GAP_LAST);
            HOLD:    rel_evt = (cnt_q == HOLD_LAST);
            RUN: begin
                if (req_valid && ready_q) begin
                    if (req_mask != '0) begin
                        act_d   = req_mask;
                        mrst_d  = mrst_q | req_mask;
                        state_d = HOLD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        if (rel_evt) begin
            mrst_d = mrst_q & ~pick;
            pend_d = src & ~pick;
            cnt_d  = '0;
            if (pend_d == '0) begin
                state_d = RUN;
                done_d  = 1'b1;
            end else begin
                state_d = RELEASE;
            end
        end
        if (state_d != state_q) cnt_d = '0;
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            mrst_q  <= '1;
            act_q   <= '1;
            pend_q  <= '1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mrst_q  <= mrst_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench: default 3-member instance plus a 1-member, 1-cycle-gap corner.
`timescale 1ns/1ps
module tb_clock_group_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_mask = 3'b000;
    logic [2:0] mclk, mrst;
    logic       ready, done, busy;
    logic [0:0] c_mclk, c_mrst;
    logic       c_ready, c_done, c_busy;
    logic       c_req_valid = 1'b0;
    logic [0:0] c_req_mask = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    clock_group_reset_sequencer dut (
        .clock(clock), .reset(reset),
        .auto_out_member_clock(mclk), .auto_out_member_reset(mrst),
        .req_valid(req_valid), .req_mask(req_mask),
        .req_ready(ready), .done(done), .busy(busy)
    );

    clock_group_reset_sequencer #(.NUM_MEMBERS(1), .GAP_CYCLES(1), .HOLD_CYCLES(8)) dut_c (
        .clock(clock), .reset(reset),
        .auto_out_member_clock(c_mclk), .auto_out_member_reset(c_mrst),
        .req_valid(c_req_valid), .req_mask(c_req_mask),
        .req_ready(c_ready), .done(c_done), .busy(c_busy)
    );

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_mask = 3'b000;
        repeat (5) @(posedge clock);
        #1;
        checks++; if (mrst !== 3'b111) begin errors++; $display("FAIL reset_mrst: got %b expected 111", mrst); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (c_mrst !== 1'b1) begin errors++; $display("FAIL reset_c_mrst: got %b expected 1", c_mrst); end
        checks++; if (mclk !== 3'b111) begin errors++; $display("FAIL reset_mclk_hi: got %b expected 111", mclk); end
        @(negedge clock); #1;
        checks++; if (mclk !== 3'b000) begin errors++; $display("FAIL reset_mclk_lo: got %b expected 000", mclk); end
    endtask

    // Expects reset to be low on entry; releases it just after a rising edge.
    task automatic test_powerup(input string tag);
        int rel[3];
        int done_n, done_at, c_rel, c_done_at;
        rel = '{-1, -1, -1};
        done_n = 0; done_at = -1; c_rel = -1; c_done_at = -1;
        @(posedge clock); #1; reset = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock); #1;
            for (int i = 0; i < 3; i++) if (rel[i] < 0 && mrst[i] === 1'b0) rel[i] = k;
            if (done === 1'b1) begin done_n++; done_at = k; end
            if (c_rel < 0 && c_mrst[0] === 1'b0) c_rel = k;
            if (c_done_at < 0 && c_done === 1'b1) c_done_at = k;
        end
        checks++; if (rel[0] != 18) begin errors++; $display("FAIL %s_rel0: got %0d expected 18", tag, rel[0]); end
        checks++; if (rel[1] != 34) begin errors++; $display("FAIL %s_rel1: got %0d expected 34", tag, rel[1]); end
        checks++; if (rel[2] != 50) begin errors++; $display("FAIL %s_rel2: got %0d expected 50", tag, rel[2]); end
        checks++; if (done_n != 1 || done_at != 50) begin errors++; $display("FAIL %s_done: got %0d pulses at %0d expected 1 at 50", tag, done_n, done_at); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL %s_run: got ready=%b busy=%b expected 1 0", tag, ready, busy); end
        checks++; if (c_rel != 3) begin errors++; $display("FAIL %s_corner_rel: got %0d expected 3", tag, c_rel); end
        checks++; if (c_done_at != 3) begin errors++; $display("FAIL %s_corner_done: got %0d expected 3", tag, c_done_at); end
    endtask

    task automatic test_rereset();
        int rel0, rel2, done_n, done_at;
        logic m1_seen;
        rel0 = -1; rel2 = -1; done_n = 0; done_at = -1; m1_seen = 1'b0;
        req_valid = 1'b1; req_mask = 3'b101;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin
                req_valid = 1'b0;
                checks++; if (mrst !== 3'b101 || busy !== 1'b1 || ready !== 1'b0) begin
                    errors++; $display("FAIL rereset_hold: got mrst=%b busy=%b ready=%b expected 101 1 0", mrst, busy, ready);
                end
            end
            if (rel0 < 0 && mrst[0] === 1'b0) rel0 = k;
            if (rel2 < 0 && mrst[2] === 1'b0) rel2 = k;
            if (mrst[1] !== 1'b0) m1_seen = 1'b1;
            if (done === 1'b1) begin done_n++; done_at = k; end
        end
        checks++; if (rel0 != 9) begin errors++; $display("FAIL rereset_rel0: got %0d expected 9", rel0); end
        checks++; if (rel2 != 25) begin errors++; $display("FAIL rereset_rel2: got %0d expected 25", rel2); end
        checks++; if (m1_seen !== 1'b0) begin errors++; $display("FAIL rereset_m1: got %b expected 0", m1_seen); end
        checks++; if (done_n != 1 || done_at != 25) begin errors++; $display("FAIL rereset_done: got %0d pulses at %0d expected 1 at 25", done_n, done_at); end
    endtask

    task automatic test_zero_mask();
        req_valid = 1'b1; req_mask = 3'b000;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (mrst !== 3'b000 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_state: got mrst=%b ready=%b busy=%b expected 000 1 0", mrst, ready, busy);
        end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL zero_after: got done=%b ready=%b expected 0 1", done, ready); end
    endtask

    task automatic test_busy_request();
        logic early;
        int done_at;
        early = 1'b0; done_at = -1;
        req_valid = 1'b1; req_mask = 3'b001;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin
                checks++; if (mrst !== 3'b001 || ready !== 1'b0) begin errors++; $display("FAIL busy_start: got mrst=%b ready=%b expected 001 0", mrst, ready); end
            end
            if (k >= 2 && k <= 8 && (mrst !== 3'b001 || done !== 1'b0)) early = 1'b1;
            if (k == 9) begin
                checks++; if (mrst !== 3'b000 || done !== 1'b1 || ready !== 1'b1) begin
                    errors++; $display("FAIL busy_run: got mrst=%b done=%b ready=%b expected 000 1 1", mrst, done, ready);
                end
            end
            if (k == 10) begin
                checks++; if (mrst !== 3'b001 || busy !== 1'b1 || ready !== 1'b0) begin
                    errors++; $display("FAIL busy_second: got mrst=%b busy=%b ready=%b expected 001 1 0", mrst, busy, ready);
                end
            end
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL busy_ignored: got %b expected 0", early); end
        req_valid = 1'b0;
        for (int k = 11; k <= 30 && done_at < 0; k++) begin
            @(posedge clock); #1;
            if (done === 1'b1) done_at = k;
        end
        checks++; if (done_at != 18) begin errors++; $display("FAIL busy_done: got %0d expected 18", done_at); end
        checks++; if (mrst !== 3'b000 || ready !== 1'b1) begin errors++; $display("FAIL busy_end: got mrst=%b ready=%b expected 000 1", mrst, ready); end
    endtask

    task automatic test_mid_reset();
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1; reset = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clock); #1;
            if (k == 18) begin
                checks++; if (mrst !== 3'b110) begin errors++; $display("FAIL mid_rel0: got %b expected 110", mrst); end
            end
        end
        #2; reset = 1'b0;
        #1;
        checks++; if (mrst !== 3'b111) begin errors++; $display("FAIL mid_async: got %b expected 111", mrst); end
        checks++; if (done !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_state: got done=%b ready=%b busy=%b expected 0 0 1", done, ready, busy);
        end
        repeat (4) @(posedge clock);
        test_powerup("after_mid");
    endtask

    initial begin
        test_reset();
        test_powerup("powerup");
        test_rereset();
        test_zero_mask();
        test_busy_request();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_group_reset_sequencer.md
CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 Parameter NUM_MEMBERS, default 3: number of clock-group members driven; legal range 1..8.
REQ-002 Parameter GAP_CYCLES, default 16: cycles between successive member reset releases; legal range 1..255.
REQ-003 Parameter HOLD_CYCLES, default 8: cycles a software-requested re-reset is held asserted; legal range 1..255.
REQ-004 clock  input  1  single clock for all logic; member clocks are forwarded copies of it.
REQ-005 reset  input  1  asynchronous assert, active-low; 0 = in reset.
REQ-006 auto_out_member_clock  output  NUM_MEMBERS  each bit driven directly from clock, no gating.
REQ-007 auto_out_member_reset  output  NUM_MEMBERS  per-member reset, active-high, registered.
REQ-008 req_valid  input  1  software re-reset request valid.
REQ-009 req_mask  input  NUM_MEMBERS  members to re-reset; sampled on handshake.
REQ-010 req_ready  output  1  high only in state RUN.
REQ-011 done  output  1  one-cycle pulse when a sequence completes.
REQ-012 busy  output  1  high in every state except RUN.

Function
REQ-013 The block SHALL pass reset through a 2-flop synchronizer (async assert, sync deassert) before using it; this is the internal reset.
REQ-014 States SHALL be: SYNC, RELEASE, RUN, HOLD.
REQ-015 SYNC: all member resets SHALL be 1; the gap counter SHALL count GAP_CYCLES; on reaching GAP_CYCLES-1 the FSM SHALL go to RELEASE with index = 0.
REQ-016 RELEASE: the block SHALL deassert auto_out_member_reset[index] on RELEASE entry and after each gap expiry; index SHALL increment every GAP_CYCLES cycles.
REQ-016a Member resets SHALL release in ascending index order; member i SHALL release at least i*GAP_CYCLES cycles after member 0.
REQ-017 After the last selected member releases, the FSM SHALL go to RUN and pulse done for exactly one cycle.
REQ-018 In RELEASE, members not in the active mask SHALL be skipped with zero cycles consumed; after power-up/reset the active mask is all-ones.
REQ-019 RUN: req_ready = 1; a handshake occurs when req_valid && req_ready.
REQ-020 On handshake with req_mask != 0: the block SHALL latch req_mask as the active mask; in the next cycle it SHALL set those resets to 1 and enter HOLD.
REQ-021 A handshake with req_mask == 0 SHALL be accepted, change no reset, and pulse done the following cycle.
REQ-022 HOLD SHALL last HOLD_CYCLES cycles, then go to RELEASE with index = 0, using the active mask.
REQ-023 Resets of members not in the active mask SHALL remain 0 throughout HOLD and RELEASE.
REQ-024 req_valid while req_ready = 0 SHALL be ignored; no request is queued.
REQ-025 The gap and hold counters SHALL be 8 bits, clear on every state entry, and never wrap within a state.
REQ-026 req_mask bits at or above NUM_MEMBERS do not exist; done and req_ready SHALL be registered.

Reset
REQ-027 While reset = 0, all auto_out_member_reset bits SHALL be 1 immediately (asynchronously); done = 0, req_ready = 0, busy = 1, FSM = SYNC, index = 0, active mask = all-ones.
REQ-028 reset asserted mid-RELEASE or mid-HOLD SHALL abort the sequence; all members SHALL re-reset and the full power-up sequence SHALL restart after deassertion.
REQ-029 auto_out_member_clock SHALL toggle during reset.

Verification
REQ-030 Power-up, defaults: reset low 5 cycles then high -> member resets release at 2+16, 2+32, 2+48 cycles (+/-1) after reset deassertion; done pulses once; req_ready = 1 afterward.
REQ-031 Re-reset: in RUN, req_mask = 3'b101 -> member 0 and member 2 reset for 8 cycles; member 0 releases at HOLD exit, member 2 releases 16 cycles later; member 1 stays 0 throughout; done pulses once.
REQ-032 Zero mask: req_mask = 3'b000 -> no reset bit changes; done pulses the cycle after the handshake; FSM stays RUN.
REQ-033 Busy request: req_valid held high during HOLD -> no second sequence starts; when RUN is reached, the held req_valid completes a handshake in that first RUN cycle.
REQ-034 Mid-sequence reset: reset driven low 1 cycle after member 0 releases -> all three resets go 1 asynchronously; after reset deassertion the full REQ-030 timing repeats.
REQ-035 Parameter corner: NUM_MEMBERS = 1, GAP_CYCLES = 1 -> member 0 releases 3 cycles after reset deassertion; done follows.
